// File: rtl/neuron_mac_seq.sv
// Time-multiplexed single neuron: runtime-loadable weights/bias, one MAC per clock,
// valid/ready handshakes on the input vector and on the result.
//
// state | meaning
// IDLE  | waiting for an input vector; config writes accepted
// ACC   | one product accumulated per clock, idx walks 0..N_IN-1
// OUT   | result held on out_data/out_ovf until out_ready
module neuron_mac_seq #(
    parameter int N_IN  = 10,
    parameter int IN_W  = 9,
    parameter int W_W   = 10,
    parameter int B_W   = 8,
    parameter int OUT_W = 8,
    parameter int SHIFT = 10,
    parameter bit SAT   = 1'b1,
    parameter bit ACT   = 1'b0,
    localparam int AW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_vec,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [W_W-1:0]         cfg_data,
    input  logic                   bias_we,
    input  logic [B_W-1:0]         bias_data,
    output logic                   cfg_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_ovf
);

    localparam int PW    = IN_W + W_W;
    localparam int ACC_W = PW - SHIFT + AW + 2;
    localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [N_IN*IN_W-1:0]     in_q, in_d;
    logic signed [W_W-1:0]    w_q [N_IN];
    logic signed [W_W-1:0]    w_d [N_IN];
    logic signed [B_W-1:0]    bias_q, bias_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     out_ovf_q, out_ovf_d;

    logic                     cfg_open;
    logic signed [IN_W-1:0]   in_el;
    logic signed [W_W-1:0]    w_el;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_sh;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [OUT_W-1:0]  res;
    logic                     res_ovf;

    assign cfg_open = (state_q == IDLE);

    // Datapath: current product and final result from the last accumulation step.
    always_comb begin
        in_el   = $signed(in_q[int'(idx_q)*IN_W +: IN_W]);
        w_el    = w_q[idx_q];
        prod    = PW'(in_el) * PW'(w_el);
        prod_sh = prod >>> SHIFT;
        acc_sum = acc_q + ACC_W'(prod_sh);
        res     = acc_sum[OUT_W-1:0];
        res_ovf = 1'b0;
        if (SAT) begin
            if (acc_sum > OMAX) begin
                res     = OMAX[OUT_W-1:0];
                res_ovf = 1'b1;
            end else if (acc_sum < OMIN) begin
                res     = OMIN[OUT_W-1:0];
                res_ovf = 1'b1;
            end
        end else begin
            res_ovf = (ACC_W'(res) != acc_sum);
        end
        if (ACT && res[OUT_W-1]) res = '0;
    end

    // Config writes land before a same-cycle input handshake, so bias_d feeds acc_d.
    always_comb begin
        w_d    = w_q;
        bias_d = bias_q;
        if (cfg_open && cfg_we && (int'(cfg_addr) < N_IN)) w_d[cfg_addr] = cfg_data;
        if (cfg_open && bias_we) bias_d = bias_data;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        in_d       = in_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_d    = in_vec;
                    acc_d   = ACC_W'(bias_d);
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(N_IN - 1)) begin
                    out_data_d = res;
                    out_ovf_d  = res_ovf;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            in_q       <= '0;
            w_q        <= '{default: '0};
            bias_q     <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            in_q       <= in_d;
            w_q        <= w_d;
            bias_q     <= bias_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: wrap, saturating and ReLU variants share one stimulus.
module tb_neuron_mac_seq;
    localparam int N_IN = 10;
    localparam int IN_W = 9;
    localparam int W_W  = 10;
    localparam int B_W  = 8;
    localparam int OUT_W = 8;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, cfg_we, bias_we, out_ready;
    logic [N_IN*IN_W-1:0] in_vec;
    logic [AW-1:0] cfg_addr;
    logic [W_W-1:0] cfg_data;
    logic [B_W-1:0] bias_data;

    logic in_ready_w, cfg_ready_w, out_valid_w, out_ovf_w;
    logic in_ready_s, cfg_ready_s, out_valid_s, out_ovf_s;
    logic in_ready_r, cfg_ready_r, out_valid_r, out_ovf_r;
    logic [OUT_W-1:0] out_data_w, out_data_s, out_data_r;

    int checks = 0;
    int errors = 0;
    int lat = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.SAT(1'b0), .ACT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w), .in_vec(in_vec),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bias_we(bias_we),
        .bias_data(bias_data), .cfg_ready(cfg_ready_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_ovf(out_ovf_w));

    neuron_mac_seq #(.SAT(1'b1), .ACT(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_vec(in_vec),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bias_we(bias_we),
        .bias_data(bias_data), .cfg_ready(cfg_ready_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s));

    neuron_mac_seq #(.SAT(1'b1), .ACT(1'b1)) u_relu (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r), .in_vec(in_vec),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .bias_we(bias_we),
        .bias_data(bias_data), .cfg_ready(cfg_ready_r), .out_valid(out_valid_r),
        .out_ready(out_ready), .out_data(out_data_r), .out_ovf(out_ovf_r));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic set_all_in(input logic [IN_W-1:0] v);
        for (int k = 0; k < N_IN; k++) in_vec[k*IN_W +: IN_W] = v;
    endtask

    task automatic wr_w(input int addr, input logic [W_W-1:0] d);
        cfg_addr = AW'(addr);
        cfg_data = d;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic start_vec();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        bias_we  = 1'b0;
        lat      = 0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid_s && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, out_valid_s, 1'b1);
        chk({tag, "_lat"}, lat, N_IN);
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_pop_valid"}, out_valid_s, 1'b0);
        chk({tag, "_pop_inrdy"}, in_ready_s, 1'b1);
    endtask

    initial begin
        logic stable;
        logic seen;
        rst_n = 1'b0;
        in_valid = 1'b0; cfg_we = 1'b0; bias_we = 1'b0; out_ready = 1'b0;
        cfg_addr = '0; cfg_data = '0; bias_data = '0; in_vec = '0;
        tick(); tick();
        chk("rst_valid", out_valid_s, 1'b0);
        chk("rst_data", out_data_s, 8'h00);
        chk("rst_ovf", out_ovf_s, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst_inrdy", in_ready_s, 1'b1);
        chk("rst_cfgrdy", cfg_ready_s, 1'b1);

        // All weights 0x100, inputs 100: 25 per term, 250 total.
        for (int k = 0; k < N_IN; k++) wr_w(k, 10'h100);
        set_all_in(9'd100);
        start_vec();
        wait_out("t1");
        chk("t1_wrap_data", out_data_w, 8'hFA);
        chk("t1_wrap_ovf", out_ovf_w, 1'b1);
        chk("t1_sat_data", out_data_s, 8'h7F);
        chk("t1_sat_ovf", out_ovf_s, 1'b1);
        chk("t1_relu_data", out_data_r, 8'h7F);
        pop("t1");

        set_all_in(9'd10);
        start_vec();
        wait_out("t2");
        chk("t2_sat_data", out_data_s, 8'h14);
        chk("t2_sat_ovf", out_ovf_s, 1'b0);
        chk("t2_wrap_data", out_data_w, 8'h14);
        chk("t2_wrap_ovf", out_ovf_w, 1'b0);
        pop("t2");

        // Floor shift: -1 * 1 >>> 10 = -1.
        wr_w(0, 10'd1);
        for (int k = 1; k < N_IN; k++) wr_w(k, 10'd0);
        set_all_in(9'd100);
        in_vec[0 +: IN_W] = 9'h1FF;
        start_vec();
        wait_out("t3");
        chk("t3_wrap_data", out_data_w, 8'hFF);
        chk("t3_sat_data", out_data_s, 8'hFF);
        chk("t3_sat_ovf", out_ovf_s, 1'b0);
        chk("t3_relu_data", out_data_r, 8'h00);

        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_data_s !== 8'hFF || out_valid_s !== 1'b1) stable = 1'b0;
        end
        chk("t4_stable", stable, 1'b1);
        chk("t4_inrdy", in_ready_s, 1'b0);
        chk("t4_cfgrdy", cfg_ready_s, 1'b0);
        pop("t4");

        // Writes during ACC are dropped; -256*1 >>> 10 = -1.
        in_vec[0 +: IN_W] = 9'h100;
        start_vec();
        cfg_addr = '0; cfg_data = 10'd8; cfg_we = 1'b1;
        bias_data = 8'd3; bias_we = 1'b1;
        tick();
        cfg_we = 1'b0; bias_we = 1'b0;
        wait_out("t5a");
        chk("t5a_sat_data", out_data_s, 8'hFF);
        pop("t5a");

        // Same writes alongside the handshake: -2048 >>> 10 = -2, plus bias 3 = 1.
        cfg_addr = '0; cfg_data = 10'd8; cfg_we = 1'b1;
        bias_data = 8'd3; bias_we = 1'b1;
        start_vec();
        wait_out("t5b");
        chk("t5b_sat_data", out_data_s, 8'h01);
        chk("t5b_relu_data", out_data_r, 8'h01);
        chk("t5b_wrap_data", out_data_w, 8'h01);
        pop("t5b");

        set_all_in(9'd100);
        start_vec();
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid_s, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("t6_inrdy", in_ready_s, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid_s !== 1'b0) seen = 1'b1;
        end
        chk("t6_no_result", seen, 1'b0);
        for (int k = N_IN; k < 16; k++) wr_w(k, 10'h100);
        start_vec();
        wait_out("t6");
        chk("t6_sat_data", out_data_s, 8'h00);
        chk("t6_sat_ovf", out_ovf_s, 1'b0);
        chk("t6_wrap_data", out_data_w, 8'h00);
        pop("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
